uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_transmitter among NUM_REQ byte producers (e.g. Hamming encoder, status reporter).
//   Round-robin arbitration over valid/ready byte requests.
//   Issues one tx_start pulse per granted byte and holds tx_data stable for the whole frame.
//   Tracks tx_busy to detect frame completion and flags a transmitter that never goes busy.
// PARAMETERS
//   NUM_REQ       4   number of requesters, >= 2
//   BUSY_TIMEOUT  4   cycles to wait in WAIT_ACK for tx_busy=1 before error, >= 2
//   GW            $clog2(NUM_REQ)   grant index width (localparam)
// PORTS
//   clk          in   1            clock
//   rst_n        in   1            reset, asynchronous, active-low
//   req_valid    in   NUM_REQ      per-requester byte valid
//   req_data     in   8*NUM_REQ    byte of requester i at [8*i+7:8*i]
//   req_ready    out  NUM_REQ      one-hot accept; byte transferred when valid&ready at posedge
//   tx_start     out  1            to transmitter; 1-cycle pulse
//   tx_data      out  8            to transmitter; registered, stable from ISSUE until frame done
//   tx_busy      in   1            from transmitter
//   grant_id     out  GW           index of requester owning the current/last frame
//   active       out  1            state != IDLE
//   err_no_busy  out  1            1-cycle pulse: tx_busy never rose after tx_start
// BEHAVIOUR
//   Reset (async, rst_n=0): outputs and state cleared.
//   - State=IDLE; tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0, err_no_busy=0.
//   - last_grant=NUM_REQ-1, so requester 0 has first priority.
//   - Reset mid-frame abandons the byte; no replay.
//   FSM IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> IDLE.
//   IDLE:
//   - Search order last_grant+1, +2, ... mod NUM_REQ (wraps at NUM_REQ-1).
//   - If tx_busy=0 and any req_valid: req_ready is combinational one-hot for the first valid index.
//   - On that posedge: tx_data<=byte, grant_id<=winner, -> ISSUE.
//   - If tx_busy=1 or no req_valid: req_ready=0, stay.
//   ISSUE:
//   - tx_start=1 for exactly this cycle; timeout counter cleared; -> WAIT_ACK.
//   WAIT_ACK (transmitter raises tx_busy the cycle after tx_start):
//   - tx_busy=1 -> WAIT_DONE.
//   - Otherwise count; after BUSY_TIMEOUT cycles without busy: err_no_busy=1 for 1 cycle, -> IDLE.
//   - last_grant<=grant_id on timeout too, so the byte is dropped and priority still rotates.
//   WAIT_DONE:
//   - Stay while tx_busy=1.
//   - tx_busy=0 -> IDLE; last_grant<=grant_id.
//   req_ready is 0 outside IDLE.
//   - A valid requester holds its byte; valid drop without grant is legal.
//   tx_data and grant_id change only on an IDLE accept.
//   Throughput: minimum 3 overhead cycles (IDLE accept, ISSUE, first WAIT_ACK) per frame.
//   - Back-to-back grants require tx_busy=0 in IDLE.
//   Simultaneous valids: exactly one accepted per frame; losers keep valid high.
//   - Starvation-free: a held request is granted within NUM_REQ frames.
// TESTING
//   1. req_valid=0001, data0=0xA5, transmitter model attached ->
//      req_ready=0001 one cycle, tx_start next cycle, tx_data=0xA5, grant_id=0.
//      After tx_busy falls: active=0.
//   2. req_valid=1111 held, data=0x10,0x11,0x12,0x13 ->
//      frames 0x10,0x11,0x12,0x13,0x10 in that order; one tx_start per frame.
//   3. last_grant=2, req_valid=1010 -> grant 3 first, then 1; req_ready never 2 bits.
//   4. tx_busy stub tied 0, BUSY_TIMEOUT=4, req0 valid ->
//      err_no_busy pulses 4 cycles after WAIT_ACK entry, FSM in IDLE, next grant = req1 if valid.
//   5. rst_n=0 during WAIT_DONE ->
//      all outputs 0 immediately (async); after release with req_valid=1001, requester 0 granted first.
//   6. tx_busy=1 externally while IDLE with req_valid=0100 ->
//      req_ready stays 0; granted the cycle tx_busy falls.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/transmitter bundle for the UART TX arbiter
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_busy;
   logic [GW-1:0]        grant_id;
   logic                 active;
   logic                 err_no_busy;

   // Requesters plus transmitter side
   modport master (
      output req_valid, req_data, tx_busy,
      input  req_ready, tx_start, tx_data, grant_id, active, err_no_busy
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_data, tx_busy,
      output req_ready, tx_start, tx_data, grant_id, active, err_no_busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input logic              clk,
   input logic              rst_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int IW = GW + 1;
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(BUSY_TIMEOUT - 1);
   localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [GW-1:0] r_last_grant;
   logic [GW-1:0] r_grant_id;
   logic [7:0]    r_tx_data;
   logic [CW-1:0] r_cnt;
   logic          r_err;

   logic [GW-1:0] w_winner;
   logic [IW-1:0] w_idx;
   logic          w_found;
   logic [7:0]    w_byte;
   logic          w_accept;
   logic          w_timeout;
   logic          w_release;

   // Find the first valid requester after the last one served, wrapping at NUM_REQ-1
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = {1'b0, r_last_grant} + IW'(k);
         if (w_idx >= IW'(NUM_REQ)) begin
            w_idx = w_idx - IW'(NUM_REQ);
         end
         if (!w_found && bus.req_valid[w_idx[GW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[GW-1:0];
         end
      end
   end

   assign w_byte = bus.req_data[{w_winner, 3'b000} +: 8];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-state strobes
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_timeout = 1'b0;
      w_release = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            // A busy transmitter (e.g. still finishing someone else's frame) blocks new grants
            if (!bus.tx_busy && w_found) begin
               w_accept = 1'b1;
               w_next   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_next = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (bus.tx_busy) begin
               w_next = S_WAIT_DONE;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               w_release = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Frame datapath: latch the granted byte, rotate priority, time out a silent transmitter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_data    <= '0;
         r_grant_id   <= '0;
         r_last_grant <= LAST_INIT;
         r_cnt        <= '0;
         r_err        <= 1'b0;
      end else begin
         if (w_accept) begin
            r_tx_data  <= w_byte;
            r_grant_id <= w_winner;
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT_ACK && !bus.tx_busy && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
         end
         // A timed-out byte is dropped but still counts as served so priority moves on
         if (w_timeout || w_release) begin
            r_last_grant <= r_grant_id;
         end
         r_err <= w_timeout;
      end
   end

   assign bus.req_ready   = w_accept ? (NUM_REQ'(1) << w_winner) : '0;
   assign bus.tx_start    = (r_state == S_ISSUE);
   assign bus.tx_data     = r_tx_data;
   assign bus.grant_id    = r_grant_id;
   assign bus.active      = (r_state != S_IDLE);
   assign bus.err_no_busy = r_err;
endmodule
